// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
// Shared definitions for the PISO serial transmitter:
//   state_t              - frame FSM state encoding (IDLE, START, DATA, STOP)
//   DEFAULT_DATA_W       - default payload width in bits
//   DEFAULT_CLKS_PER_BIT - default clock cycles per serial bit
//   CNT_W                - width of the bit-period cycle counter (covers 1..255)
//   frame_bits()         - number of bit slots in one frame (start + data + stop)
// ---------------------------------------------------------------------------
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEFAULT_DATA_W       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 4;
   localparam int CNT_W                = 8;

   function automatic int frame_bits(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/piso_serializer_tx_bit_tick_gen.sv
// ---------------------------------------------------------------------------
// bit_tick_gen
// Bit-period cycle counter. Counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle tick in the last cycle of each bit period; the counter wraps to 0
// on that same edge so the next bit starts cleanly.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset
//   enable  - count while high; counter held at 0 while low
//   restart - force the counter back to 0 (frame start)
//   tick    - high in the final cycle of a bit period
// ---------------------------------------------------------------------------
module bit_tick_gen
   import serializer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic restart,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_r;

   // Tick is decoded from the counter so the FSM can act on the same edge
   // the counter wraps.
   assign tick = enable && (cnt_r == LAST_CNT);

   // Cycle counter: cleared on reset, restart or while disabled; wraps at bit end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (restart || !enable) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == LAST_CNT) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

endmodule

// File: rtl/piso_serializer_tx.sv
// ---------------------------------------------------------------------------
// piso_serializer_tx
// Parallel-in serial-out transmitter. Accepts a DATA_W-bit word on a
// valid/ready handshake and sends it as: start bit (0), DATA_W data bits LSB
// first, stop bit (1), each bit held CLKS_PER_BIT cycles. The line idles high.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   data_in    - word to transmit
//   load_valid - requester offers data_in
//   load_ready - word can be accepted this cycle (IDLE and not in reset)
//   tx_out     - registered serial line
//   tx_busy    - high while a frame is in progress
//   done       - one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module piso_serializer_tx
   import serializer_pkg::*;
#(
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              done
);

   localparam int                IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state_r;
   logic [DATA_W-1:0] shift_r;
   logic [IDX_W-1:0]  bit_idx_r;
   logic              tx_out_r;
   logic              tx_busy_r;
   logic              done_r;
   logic              accept_s;
   logic              tick_s;
   logic              tick_en_s;

   // Ready includes rst_n directly so nothing is accepted on a reset edge.
   assign load_ready = (state_r == IDLE) && rst_n;
   assign accept_s   = load_valid && load_ready;
   assign tick_en_s  = (state_r != IDLE);

   assign tx_out  = tx_out_r;
   assign tx_busy = tx_busy_r;
   assign done    = done_r;

   bit_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (tick_en_s),
      .restart (accept_s),
      .tick    (tick_s)
   );

   // Frame FSM: drives the serial line from the shift register, one bit per tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         shift_r   <= {DATA_W{1'b0}};
         bit_idx_r <= {IDX_W{1'b0}};
         tx_out_r  <= 1'b1;
         tx_busy_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  shift_r   <= data_in;
                  bit_idx_r <= {IDX_W{1'b0}};
                  tx_out_r  <= 1'b0;
                  tx_busy_r <= 1'b1;
                  state_r   <= START;
               end else begin
                  tx_out_r  <= 1'b1;
                  tx_busy_r <= 1'b0;
               end
            end
            START: begin
               if (tick_s) begin
                  // LSB goes out first; shifting keeps the next bit at index 0.
                  tx_out_r  <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
                  bit_idx_r <= {IDX_W{1'b0}};
                  state_r   <= DATA;
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (bit_idx_r == LAST_IDX) begin
                     tx_out_r <= 1'b1;
                     state_r  <= STOP;
                  end else begin
                     tx_out_r  <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
                     bit_idx_r <= bit_idx_r + IDX_W'(1);
                  end
               end
            end
            STOP: begin
               if (tick_s) begin
                  tx_busy_r <= 1'b0;
                  done_r    <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r   <= IDLE;
               tx_out_r  <= 1'b1;
               tx_busy_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer_tx
// Two DUTs share one clock: unit 0 uses DATA_W=8/CLKS_PER_BIT=4, unit 1 uses
// DATA_W=4/CLKS_PER_BIT=1. A frame-level reference model predicts the outputs
// of every cycle and queues them; a monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_piso_serializer_tx;

   typedef struct packed {
      logic tx;
      logic busy;
      logic done;
      logic ready;
   } exp_t;

   logic        clk;
   logic        rst_v   [2];
   logic [15:0] din_v   [2];
   logic        lv_v    [2];
   logic        ready_v [2];
   logic        tx_v    [2];
   logic        busy_v  [2];
   logic        done_v  [2];

   exp_t        exp_q   [2][$];
   int          rem     [2];
   int          pos     [2];
   logic [15:0] word    [2];
   int          acc_cnt [2];

   int compared   = 0;
   int mismatched = 0;

   piso_serializer_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
      .clk        (clk),
      .rst_n      (rst_v[0]),
      .data_in    (din_v[0][7:0]),
      .load_valid (lv_v[0]),
      .load_ready (ready_v[0]),
      .tx_out     (tx_v[0]),
      .tx_busy    (busy_v[0]),
      .done       (done_v[0])
   );

   piso_serializer_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_v[1]),
      .data_in    (din_v[1][3:0]),
      .load_valid (lv_v[1]),
      .load_ready (ready_v[1]),
      .tx_out     (tx_v[1]),
      .tx_busy    (busy_v[1]),
      .done       (done_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unit_dw(input int u);
      return (u == 0) ? 8 : 4;
   endfunction

   function automatic int unit_cpb(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   // Bit slot k of a frame: 0 = start, 1..dw = data LSB first, dw+1 = stop.
   function automatic logic frame_bit(input logic [15:0] w, input int k, input int dw);
      if (k == 0) return 1'b0;
      else if (k <= dw) return w[k-1];
      else return 1'b1;
   endfunction

   // Reference model: frame timeline in cycles, one expectation per edge.
   initial begin
      for (int u = 0; u < 2; u++) begin
         rem[u] = 0; pos[u] = 0; word[u] = 16'h0; acc_cnt[u] = 0;
      end
      forever begin
         @(posedge clk);
         for (int u = 0; u < 2; u++) begin
            exp_t e;
            logic dn;
            dn = 1'b0;
            if (!rst_v[u]) begin
               rem[u] = 0;
            end else if (rem[u] > 0) begin
               pos[u] = pos[u] + 1;
               rem[u] = rem[u] - 1;
               dn = (rem[u] == 0);
            end else if (lv_v[u]) begin
               word[u]    = din_v[u];
               pos[u]     = 0;
               rem[u]     = (unit_dw(u) + 2) * unit_cpb(u);
               acc_cnt[u] = acc_cnt[u] + 1;
            end
            e.busy  = (rem[u] > 0);
            e.tx    = (rem[u] > 0) ? frame_bit(word[u], pos[u] / unit_cpb(u), unit_dw(u)) : 1'b1;
            e.done  = dn;
            e.ready = (rem[u] == 0) && rst_v[u];
            exp_q[u].push_back(e);
         end
      end
   end

   // Monitor: compares every queued expectation just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            if (exp_q[u].size() > 0) begin
               exp_t e;
               exp_t a;
               e = exp_q[u].pop_front();
               a = '{tx: tx_v[u], busy: busy_v[u], done: done_v[u], ready: ready_v[u]};
               compared++;
               if (a !== e) begin
                  mismatched++;
                  $display("FAIL unit%0d outputs at %0t: got tx/busy/done/ready=%b required %b",
                           u, $time, a, e);
               end
            end
         end
      end
   end

   task automatic send(input int u, input logic [15:0] w, input bit keep);
      int start_cnt;
      int n;
      start_cnt = acc_cnt[u];
      n = 0;
      @(negedge clk);
      din_v[u] = w;
      lv_v[u]  = 1'b1;
      while (acc_cnt[u] == start_cnt && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!keep) lv_v[u] = 1'b0;
      if (n >= 300) begin
         compared++;
         mismatched++;
         $display("FAIL unit%0d accept timeout: got no acceptance required acceptance of %h", u, w);
      end
   endtask

   task automatic wait_idle(input int u);
      int n;
      n = 0;
      while (rem[u] != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         compared++;
         mismatched++;
         $display("FAIL unit%0d idle timeout: got busy required idle", u);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_v[u] = 1'b0;
         lv_v[u]  = 1'b0;
         din_v[u] = 16'h0;
      end
      // Reset held for three edges, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_v[0] = 1'b1;
      rst_v[1] = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame 0xA5.
      send(0, 16'h00A5, 1'b0);
      wait_idle(0);

      // Back-to-back 0x3C then 0xFF with load_valid held.
      send(0, 16'h003C, 1'b1);
      send(0, 16'h00FF, 1'b0);
      wait_idle(0);

      // Load of 0x00 offered during DATA must be ignored.
      send(0, 16'h00A5, 1'b0);
      repeat (12) @(negedge clk);
      din_v[0] = 16'h0000;
      lv_v[0]  = 1'b1;
      @(negedge clk);
      lv_v[0]  = 1'b0;
      wait_idle(0);

      // Reset during data bit 3, then a clean 0x81 frame.
      send(0, 16'h00A5, 1'b0);
      repeat (17) @(negedge clk);
      rst_v[0] = 1'b0;
      @(negedge clk);
      rst_v[0] = 1'b1;
      @(negedge clk);
      send(0, 16'h0081, 1'b0);
      wait_idle(0);

      // Narrow, fast unit: 0x9, then random words.
      send(1, 16'h0009, 1'b0);
      wait_idle(1);
      for (int i = 0; i < 6; i++) begin
         send(1, 16'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
         din_v[1] = 16'($urandom_range(0, 15));
      end
      lv_v[1] = 1'b0;
      wait_idle(1);

      // Random words with random gaps and noisy data_in while busy.
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(0, 16'($urandom_range(0, 255)), 1'b0);
         din_v[0] = 16'($urandom_range(0, 255));
      end
      wait_idle(0);

      if (acc_cnt[0] < 12 || acc_cnt[1] < 7) begin
         compared++;
         mismatched++;
         $display("FAIL frame count: got %0d/%0d required at least 12/7", acc_cnt[0], acc_cnt[1]);
      end

      repeat (2) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/piso_serializer_tx.md
PISO_SERIALIZER_TX -- requirements
Module: piso_serializer_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width in bits, legal range 2..16.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port data_in  input  DATA_W  parallel word to transmit.
REQ-006 SHALL have port load_valid  input  1  requester offers data_in.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 SHALL use states IDLE, START, DATA, STOP.
REQ-012 load_ready SHALL equal 1 exactly when state is IDLE and rst_n is high.
REQ-013 Word acceptance SHALL occur on a rising edge where load_valid and load_ready are both 1; data_in SHALL be captured into an internal shift register on that edge.
REQ-014 load_valid while load_ready is 0 SHALL be ignored; data_in changes after acceptance SHALL NOT affect the frame.
REQ-015 Frame SHALL be: start bit 0, then DATA_W data bits LSB first, then stop bit 1; each bit held for exactly CLKS_PER_BIT cycles.
REQ-016 tx_out SHALL go low in the first cycle after the acceptance edge (latency 1 cycle).
REQ-017 Transitions: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after DATA_W bit periods; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-018 Bit index counter SHALL count 0..DATA_W-1 and SHALL not wrap past DATA_W-1; cycle counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-019 tx_out SHALL be registered (no combinational path from data_in or load_valid).
REQ-020 tx_busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-021 done SHALL be 1 for exactly the first cycle after STOP completes, coinciding with the first IDLE cycle; a new word SHALL be acceptable in that same cycle (back-to-back frames with no idle gap).
REQ-022 Total frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles from first low tx_out to first IDLE cycle.
REQ-023 With CLKS_PER_BIT=1, each bit SHALL last one cycle and all rules above SHALL still hold.

Reset
REQ-024 When rst_n is 0 at a rising edge: state IDLE, tx_out 1, tx_busy 0, done 0, both counters 0, shift register 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; tx_out SHALL be 1 in the cycle after the reset edge, and no done pulse SHALL be produced for the aborted frame.
REQ-026 load_ready SHALL be 0 while rst_n is 0 and SHALL rise in the first cycle after rst_n is sampled high.

Structure
REQ-027 A shared package serializer_pkg SHALL hold the state encoding (IDLE, START, DATA, STOP) and the default DATA_W and CLKS_PER_BIT constants.
REQ-028 The bit-period cycle counter SHALL be one sub-module, bit_tick_gen, producing a one-cycle tick at each bit boundary and restartable by the FSM.

Verification (DATA_W=8, CLKS_PER_BIT=4 unless noted)
REQ-029 Reset: hold rst_n=0 for 3 cycles, then release -> tx_out=1, tx_busy=0, done=0 throughout reset; load_ready=1 in the first cycle after release.
REQ-030 Single frame: load 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles; 40 busy cycles; done pulses once, 1 cycle wide.
REQ-031 Back-to-back: hold load_valid=1 with 0x3C then 0xFF -> second start bit begins exactly 1 cycle after the done cycle; no gap longer than 1 cycle of idle-high.
REQ-032 Ignore while busy: pulse load_valid with 0x00 during the DATA state of a 0xA5 frame -> frame bits unchanged, no extra frame sent.
REQ-033 Mid-frame reset: assert rst_n=0 during data bit 3 of 0xA5 -> tx_out=1 the next cycle, no done pulse; a subsequent load of 0x81 transmits correctly.
REQ-034 CLKS_PER_BIT=1, DATA_W=4: load 0x9 -> tx_out 0,1,0,0,1,1 on consecutive cycles; done in cycle 7 after the acceptance edge.
